// File: rtl/ntp_irq_pkg.sv
// Shared types and constants for the NTP interrupt controller.
package ntp_irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2,
    RETURN   = 2'd3
  } irq_state_e;

  localparam int VEC_STRIDE = 4;
  localparam int OPCODE_MSB = 23;
  localparam int OPCODE_LSB = 20;

  // Vector address for source idx, wrapping modulo 256.
  function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [7:0] idx);
    return base + 8'(VEC_STRIDE) * idx;
  endfunction

endpackage

// File: rtl/ntp_irq_prio_enc.sv
// Priority encoder over eligible interrupt lines.
// IRQ_ROTATE_EN: search starts at rr_ptr (round robin); otherwise the lowest index wins.
module ntp_irq_prio_enc
  import ntp_irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

`ifdef IRQ_ROTATE_EN
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_IRQ;
      if (!valid && eligible[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end
`else
  logic w_unused_rr;
  assign w_unused_rr = ^rr_ptr;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!valid && eligible[k]) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/ntp_irq_controller.sv
// Single-level interrupt controller: edge capture, mask, priority select, PC redirect and RETI return.
// IRQ_ROTATE_EN selects round-robin priority instead of fixed lowest-index priority.
module ntp_irq_controller
  import ntp_irq_pkg::*;
#(
  parameter int               NUM_IRQ  = 4,
  parameter logic [7:0]       VEC_BASE = 8'hF0,
  parameter logic [3:0]       RETI_OP  = 4'hE,
  parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_din,
  input  logic [23:0]        ins,
  input  logic [7:0]         Current_Address,
  input  logic [3:0]         flag_ex,
  output logic [7:0]         int_jmp_loc,
  output logic               int_pc_sel,
  output logic               flag_restore,
  output logic [3:0]         ret_flags,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_service
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_e         r_state;
  logic [NUM_IRQ-1:0] r_prev_req;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [7:0]         r_saved_addr;
  logic [3:0]         r_saved_flags;

  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_ack;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_rr_ptr;
  logic               w_valid;
  logic               w_reti;
  logic [7:0]         w_vec;
  logic               w_unused_ins;

  assign w_set        = irq_req & ~r_prev_req;
  assign w_eligible   = r_pending & r_mask;
  assign w_reti       = (ins[OPCODE_MSB:OPCODE_LSB] == RETI_OP);
  assign w_vec        = vec_addr(VEC_BASE, 8'(w_idx));
  assign w_ack        = NUM_IRQ'(1) << w_idx;
  assign w_unused_ins = ^ins[OPCODE_LSB-1:0];

`ifdef IRQ_ROTATE_EN
  logic [IDX_W-1:0] r_rr_ptr;
  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = '0;
`endif

  ntp_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .eligible (w_eligible),
    .rr_ptr   (w_rr_ptr),
    .idx      (w_idx),
    .valid    (w_valid)
  );

  // A new edge on the acknowledged line in the same cycle re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_req <= '0;
      r_pending  <= '0;
      r_mask     <= MASK_RST;
    end else begin
      r_prev_req <= irq_req;
      r_pending  <= (r_pending & ~irq_ack) | w_set;
      if (mask_wr) r_mask <= mask_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_saved_addr  <= '0;
      r_saved_flags <= '0;
      int_jmp_loc   <= '0;
      int_pc_sel    <= 1'b0;
      flag_restore  <= 1'b0;
      ret_flags     <= '0;
      irq_ack       <= '0;
      in_service    <= 1'b0;
`ifdef IRQ_ROTATE_EN
      r_rr_ptr      <= '0;
`endif
    end else begin
      int_jmp_loc  <= '0;
      int_pc_sel   <= 1'b0;
      flag_restore <= 1'b0;
      ret_flags    <= '0;
      irq_ack      <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state       <= DISPATCH;
            int_pc_sel    <= 1'b1;
            int_jmp_loc   <= w_vec;
            irq_ack       <= w_ack;
            in_service    <= 1'b1;
            r_saved_addr  <= Current_Address + 8'd1;
            r_saved_flags <= flag_ex;
`ifdef IRQ_ROTATE_EN
            r_rr_ptr      <= (w_idx == IDX_W'(NUM_IRQ - 1)) ? '0 : w_idx + IDX_W'(1);
`endif
          end
        end
        DISPATCH: r_state <= SERVICE;
        SERVICE: begin
          if (w_reti) begin
            r_state      <= RETURN;
            int_pc_sel   <= 1'b1;
            int_jmp_loc  <= r_saved_addr;
            flag_restore <= 1'b1;
            ret_flags    <= r_saved_flags;
          end
        end
        default: begin
          r_state    <= IDLE;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
